// File: rtl/timer_bank.sv
// timer_bank: CHANNELS independent programmable interval timers with per-channel
// period and mode (off / periodic / one-shot), a global pause, and registered outputs.
module timer_bank #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 25,
    parameter int RESET_PERIOD = 13500000,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pause,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_ch,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [1:0]          cfg_mode,
    output logic [CHANNELS-1:0] overflow,
    output logic [CHANNELS-1:0] toggle,
    output logic [CHANNELS-1:0] running
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [WIDTH-1:0] RST_PERIOD    = WIDTH'(RESET_PERIOD);
    localparam logic [WIDTH-1:0] ONE           = WIDTH'(1);
    localparam logic [1:0]       MODE_PERIODIC = 2'd1;
    localparam logic [1:0]       MODE_ONESHOT  = 2'd2;

    logic [WIDTH-1:0]    period_r  [CHANNELS];
    logic [WIDTH-1:0]    counter_r [CHANNELS];
    logic [1:0]          mode_r    [CHANNELS];
    state_t              state_r   [CHANNELS];
    logic [CHANNELS-1:0] wr_sel_s;

    // Modes 0 and 3 both park the channel; only 1 and 2 count.
    function automatic logic mode_runs(input logic [1:0] mode);
        return (mode == MODE_PERIODIC) || (mode == MODE_ONESHOT);
    endfunction

    // Decode the config write; out-of-range channel numbers match no channel.
    always_comb begin
        wr_sel_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_we && (32'(cfg_ch) == 32'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    // Per-channel counter, FSM and output flops; a write beats a same-cycle terminal count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                counter_r[i] <= '0;
                period_r[i]  <= RST_PERIOD;
                mode_r[i]    <= MODE_PERIODIC;
                state_r[i]   <= RUN;
                overflow[i]  <= 1'b0;
                toggle[i]    <= 1'b0;
                running[i]   <= 1'b1;
            end else if (wr_sel_s[i]) begin
                counter_r[i] <= '0;
                period_r[i]  <= cfg_period;
                mode_r[i]    <= cfg_mode;
                overflow[i]  <= 1'b0;
                if (mode_runs(cfg_mode)) begin
                    state_r[i] <= RUN;
                    running[i] <= 1'b1;
                end else begin
                    state_r[i] <= IDLE;
                    running[i] <= 1'b0;
                end
            end else begin
                case (state_r[i])
                    RUN: begin
                        if (pause) begin
                            overflow[i] <= 1'b0;
                        end else if (counter_r[i] == period_r[i]) begin
                            counter_r[i] <= '0;
                            overflow[i]  <= 1'b1;
                            toggle[i]    <= ~toggle[i];
                            if (mode_r[i] == MODE_ONESHOT) begin
                                state_r[i] <= IDLE;
                                running[i] <= 1'b0;
                            end else begin
                                state_r[i] <= RUN;
                                running[i] <= 1'b1;
                            end
                        end else begin
                            counter_r[i] <= counter_r[i] + ONE;
                            overflow[i]  <= 1'b0;
                        end
                    end
                    IDLE: begin
                        counter_r[i] <= '0;
                        overflow[i]  <= 1'b0;
                        running[i]   <= 1'b0;
                    end
                    default: begin
                        counter_r[i] <= '0;
                        overflow[i]  <= 1'b0;
                        state_r[i]   <= IDLE;
                        running[i]   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: a counting-based reference model predicts each
// cycle's outputs, a separate monitor pops and compares them on the falling edge.
module tb_timer_bank;

    localparam int CH = 5;
    localparam int W  = 6;
    localparam int RP = 9;

    logic          clk;
    logic          rst;
    logic          pause;
    logic          cfg_we;
    logic [2:0]    cfg_ch;
    logic [W-1:0]  cfg_period;
    logic [1:0]    cfg_mode;
    logic [CH-1:0] overflow;
    logic [CH-1:0] toggle;
    logic [CH-1:0] running;

    timer_bank #(.CHANNELS(CH), .WIDTH(W), .RESET_PERIOD(RP)) dut (
        .clk(clk), .rst(rst), .pause(pause), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_mode(cfg_mode),
        .overflow(overflow), .toggle(toggle), .running(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] ov;
        logic [CH-1:0] tg;
        logic [CH-1:0] rn;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: n = unpaused run cycles since last restart; everything else follows arithmetically.
    int unsigned m_p   [CH];
    int          m_md  [CH];
    int unsigned m_n   [CH];
    bit          m_t0  [CH];
    bit          m_adv [CH];

    function automatic bit m_run(int i);
        return (m_md[i] == 1 || m_md[i] == 2) && (m_md[i] != 2 || m_n[i] < m_p[i] + 1);
    endfunction

    function automatic bit m_tog(int i);
        return m_t0[i] ^ bit'((m_n[i] / (m_p[i] + 1)) & 1);
    endfunction

    function automatic int unsigned m_cnt(int i);
        return m_n[i] % (m_p[i] + 1);
    endfunction

    function automatic void model_edge(bit r, bit p, bit we, int ch, int per, int md);
        for (int i = 0; i < CH; i++) begin
            m_adv[i] = 1'b0;
            if (r) begin
                m_p[i] = RP; m_md[i] = 1; m_n[i] = 0; m_t0[i] = 1'b0;
            end else if (we && ch == i) begin
                m_t0[i] = m_tog(i);
                m_p[i] = per; m_md[i] = md; m_n[i] = 0;
            end else if (!p && m_run(i)) begin
                m_n[i] = m_n[i] + 1;
                m_adv[i] = 1'b1;
            end
        end
    endfunction

    task automatic cycle(bit r, bit p, bit we, int ch, int per, int md);
        exp_t e;
        rst = r; pause = p; cfg_we = we;
        cfg_ch = 3'(ch); cfg_period = W'(per); cfg_mode = 2'(md);
        @(posedge clk);
        model_edge(r, p, we, ch, per, md);
        for (int i = 0; i < CH; i++) begin
            e.ov[i] = m_adv[i] && (m_n[i] % (m_p[i] + 1) == 0);
            e.tg[i] = m_tog(i);
            e.rn[i] = m_run(i);
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic check(string name, logic [CH-1:0] act, logic [CH-1:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp_v);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared on the following falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("overflow", overflow, e.ov);
            check("toggle", toggle, e.tg);
            check("running", running, e.rn);
        end
    end

    task automatic bound_fail(string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired, got no match expected match", name);
    endtask

    initial begin
        int k;
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
        cycle(1'b1, 1'b1, 1'b1, 1, 2, 0);
        idle(22);

        cycle(1'b0, 1'b0, 1'b1, 1, 3, 1);
        cycle(1'b0, 1'b0, 1'b1, 2, 5, 2);
        idle(12);

        cycle(1'b0, 1'b0, 1'b1, 0, 0, 1);
        idle(4);
        for (int j = 0; j < 3; j++) cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        idle(3);

        // Write ch3 exactly when its counter sits at terminal count.
        k = 0;
        while (m_cnt(3) != m_p[3] && k < 40) begin idle(1); k++; end
        if (m_cnt(3) != m_p[3]) bound_fail("wait_ch3_tc");
        cycle(1'b0, 1'b0, 1'b1, 3, 4, 1);
        idle(12);

        cycle(1'b0, 1'b0, 1'b1, 5, 2, 1);
        cycle(1'b0, 1'b0, 1'b1, 7, 0, 2);
        cycle(1'b0, 1'b0, 1'b1, 1, 3, 3);
        idle(6);

        // Write during pause: takes effect, counter held until pause drops.
        cycle(1'b0, 1'b1, 1'b1, 4, 2, 1);
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        idle(8);

        cycle(1'b0, 1'b0, 1'b1, 2, 7, 1);
        k = 0;
        while (!(m_tog(2) && m_cnt(2) == 3) && k < 40) begin idle(1); k++; end
        if (!(m_tog(2) && m_cnt(2) == 3)) bound_fail("wait_ch2_cnt3");
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(12);

        cycle(1'b0, 1'b0, 1'b1, 4, 63, 1);
        idle(70);

        for (int j = 0; j < 700; j++) begin
            cycle(($urandom_range(0, 255) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 5) == 0) ? 63 : int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
# timer_bank

Multi-channel programmable interval timer. It generalises the single fixed-period free-running timer into CHANNELS independent counters, each with a runtime-loadable period and a mode: off, periodic or one-shot. It also adds a global pause. Each channel drives a one-cycle overflow pulse and a square-wave toggle output that can feed an LED or a downstream counter directly. It sits between the top-level clock and the LED/pattern logic, replacing per-LED timer instances.

## Interface
- CHANNELS, default 4: number of independent timer channels (1..16).
- WIDTH, default 25: counter/period width in bits; max period 2^WIDTH-1.
- RESET_PERIOD, default 13500000: period loaded into every channel at reset; must fit in WIDTH.

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- pause  input  1  global freeze: while high, no counter advances and no overflow is generated.
- cfg_we  input  1  config write strobe, one cycle per write.
- cfg_ch  input  max(1,$clog2(CHANNELS))  target channel; values >= CHANNELS are ignored.
- cfg_period  input  WIDTH  terminal count P; the channel overflows every P+1 cycles.
- cfg_mode  input  2  0 = off, 1 = periodic, 2 = one-shot, 3 = reserved (treated as off).
- overflow  output  CHANNELS  registered one-cycle pulse per channel at terminal count.
- toggle  output  CHANNELS  registered; inverts on every overflow of that channel.
- running  output  CHANNELS  registered; high while the channel is in RUN.

## Operation
- Per-channel state: period[WIDTH], mode[2], counter[WIDTH], FSM {IDLE, RUN}, plus the overflow, toggle and running flops.
- Reset (rst high at an edge), all channels:
  - counter = 0, period = RESET_PERIOD, mode = periodic, state = RUN.
  - overflow = 0, toggle = 0, running = 1.
  - Reset overrides cfg_we and pause.
- Config write (cfg_we high, cfg_ch < CHANNELS), target channel only:
  - period <= cfg_period, mode <= cfg_mode, counter <= 0, overflow <= 0; toggle is unchanged.
  - Mode 1 or 2: state <= RUN. Mode 0 or 3: state <= IDLE.
  - A write to a running channel restarts it from 0.
  - Other channels are unaffected.
- RUN, pause low:
  - If counter == period: counter <= 0, overflow <= 1, toggle <= ~toggle. If mode is one-shot, state <= IDLE.
  - Otherwise: counter <= counter + 1, overflow <= 0.
- RUN, pause high: counter holds, overflow <= 0, state holds.
- IDLE: counter holds 0, overflow <= 0.
- running mirrors the next state: it is registered in the same cycle as the state change.
- Arithmetic: the counter never exceeds period, so it never wraps. P = 2^WIDTH-1 is legal.
- P = 0 in periodic mode: overflow is high every unpaused cycle and toggle flips every cycle.
- Write and terminal count on the same channel in the same cycle: the write wins. No overflow pulse, no toggle flip, counter = 0.
- Write while pause is high: the write takes effect. The counter stays at 0 until pause drops.

## Timing
- Write sampled at edge k with period P, pause low:
  - counter = 0 after edge k; running = 1 after edge k.
  - counter = P after edge k+P.
  - overflow = 1 and toggle flipped after edge k+P+1, lasting exactly one cycle.
- Periodic steady state: overflow pulses are exactly P+1 cycles apart; toggle period is 2(P+1) cycles.
- Each paused cycle delays all later events by one cycle. Pause has no effect on IDLE channels.
- One-shot: running falls at edge k+P+1, the same edge that raises overflow.
- After reset release: first overflow on every channel appears RESET_PERIOD+1 cycles after the last reset edge. All channels stay in lockstep until written.
- No combinational path from any input to any output.

## Test plan
- Reset with RESET_PERIOD = 9, CHANNELS = 4 -> running = 4'b1111, toggle = 0. overflow = 4'b1111 pulses every 10 cycles, starting 10 cycles after reset release.
- Write ch1 P = 3 periodic; write ch2 P = 5 one-shot -> ch1 overflow every 4 cycles. ch2 gives a single pulse 6 cycles after its write, then running[2] = 0 and no further pulses.
- Write ch0 P = 0 periodic -> overflow[0] high every cycle, toggle[0] alternates 0/1. Hold pause for 3 cycles mid-run -> overflow[0] = 0 for those 3 cycles, and the counter does not advance.
- Write ch3 P = 4 in the exact cycle its counter == its current period -> no overflow pulse that cycle, toggle[3] unchanged, next overflow 5 cycles later.
- Write cfg_ch = 5 with CHANNELS = 4, and write ch1 mode = 3 -> no change from the out-of-range write; ch1 goes IDLE with running[1] = 0 and overflow[1] stays 0.
- Assert rst mid-run with ch2 at counter 3 and toggle[2] = 1 -> one cycle later all counters = 0, toggle = 0, overflow = 0, and periods revert to RESET_PERIOD.
